life_grid_engine: RTL and testbench
===================================

# life_grid_engine

Parametrised Conway/Life-like cellular automaton engine. It holds a ROWS×COLS cell grid in registers and advances it one generation at a time, row-serially, one row per clock. It supports dead-edge or toroidal boundaries, programmable birth/survive rules, a host load/read port, single-step and free-run control, and generation/population/stability status. It sits between the button/switch control logic and the display/readout logic in the top-level design.

## Interface
- ROWS, 48, grid height (≥3)
- COLS, 64, grid width (≥3)
- WRAP, 0, 0 = cells outside grid are dead; 1 = toroidal (row and column indices wrap)
- BIRTH_MASK, 9'b000001000, bit k set → dead cell with k live neighbours is born
- SURVIVE_MASK, 9'b000001100, bit k set → live cell with k live neighbours survives
- GEN_W, 16, generation counter width
- Derived: RW = $clog2(ROWS), PW = $clog2(ROWS*COLS+1)

Ports:
- ClkPort  in  1  system clock; all state on its rising edge
- Reset_n  in  1  reset, asynchronous, active-low; clears all state
- step  in  1  request one generation (sampled in IDLE)
- run  in  1  level; while high, generations start back-to-back
- clear  in  1  synchronous: zero all cells, gen_count, pop_count, and flags; abort any generation; go to IDLE
- wr_en  in  1  load row (IDLE only)
- wr_row  in  RW  row to load
- wr_data  in  COLS  row contents, bit j = column j
- rd_row  in  RW  readout row select
- rd_data  out  COLS  combinational grid[rd_row]; 0 if rd_row ≥ ROWS
- busy  out  1  generation in progress
- done  out  1  one-cycle pulse when a generation completes
- gen_count  out  GEN_W  completed generations since reset/clear
- pop_count  out  PW  live cells in last completed generation
- stable  out  1  last generation changed no cell
- extinct  out  1  pop_count == 0 after at least one generation

## Operation
- FSM states: IDLE, COMPUTE, DONE.
- IDLE → COMPUTE when (step | run) & ~wr_en & ~clear. Copy old row 0 to row0_buf and set r = 0, pop accumulator = 0, changed = 0.
- COMPUTE: each cycle, compute the new row r from three old rows and write it in place:
  - above: prev_buf (old row r-1); for r=0, old row ROWS-1 if WRAP, else 0.
  - current: grid[r].
  - below: grid[r+1]; for r=ROWS-1, row0_buf if WRAP, else 0.
  - Before the write, prev_buf ← old grid[r].
  - Column neighbours at j=0 and j=COLS-1 wrap if WRAP, else read as 0.
  - Neighbour count is 0..8 (4 bits). New cell = alive ? SURVIVE_MASK[n] : BIRTH_MASK[n].
  - pop accumulator += popcount(new row); changed |= (new row != old row).
  - At r = ROWS-1, go to DONE.
- DONE: done=1; gen_count += 1, wrapping modulo 2^GEN_W; pop_count ← accumulator; stable ← ~changed; extinct ← (accumulator==0). Then go to IDLE.
- wr_en in IDLE writes grid[wr_row] ← wr_data. wr_row ≥ ROWS is ignored. wr_en while busy/DONE is ignored.
- Simultaneous wr_en and step in IDLE: the write happens and the step is dropped.
- clear has priority over everything except Reset_n. Loads do not update pop_count, stable or extinct.

## Timing
- Reset values: all cells 0, busy 0, done 0, gen_count 0, pop_count 0, stable 0, extinct 0; FSM in IDLE.
- step sampled high at edge t (in IDLE): busy is high from t+1 through t+ROWS. Row r is written at edge t+1+r. done is high in cycle t+ROWS+1, and status outputs update at that same edge.
- Generation period under continuous run: ROWS+2 cycles (COMPUTE ROWS, DONE 1, IDLE 1).
- step pulses arriving while busy/DONE are dropped, not queued.
- rd_data during COMPUTE shows a mix of new and old rows. Consumers sample rd_data only when busy=0.
- Reset_n low at any time (including mid-COMPUTE) immediately forces reset values. There is no partial generation and no done pulse.

## Test plan
- Blinker, 8×8, WRAP=0: load row3=8'b00011100, then step → done at t+9; rows 2,3,4 = 8'b00001000; pop_count=3, gen_count=1, stable=0. A second step restores the original pattern.
- Block 2×2 at rows 1-2, cols 1-2, then step → grid unchanged, stable=1, pop_count=4. A single isolated cell, then step → pop_count=0, extinct=1.
- Glider in 8×8 crossing the corner: with WRAP=1 and run for 32 generations → grid equals the initial pattern and gen_count=32. With WRAP=0 → pattern degrades into a block at the edge and never returns.
- Edge rule: vertical 3-cell column at col 0, rows 3-5. WRAP=0 → rows 4 = 8'b00000011. WRAP=1 → row 4 = 8'b10000011.
- Control: wr_en during busy leaves the grid unchanged; wr_en+step together loads the row and busy stays 0; clear at r=3 → all cells 0, busy=0, no done, gen_count=0.
- Reset_n pulsed low mid-run → outputs at reset values with no clock edge needed. gen_count wrap with GEN_W=4: 16 steps → gen_count=0.

Source files
------------

// File: rtl/life_grid_engine.sv
// Row-serial Life-like automaton engine: one generation takes ROWS compute cycles plus one DONE cycle.
// No backpressure: step/run are sampled only in IDLE; requests and loads arriving while busy are dropped.
module life_grid_engine #(
  parameter int         ROWS         = 48,
  parameter int         COLS         = 64,
  parameter int         WRAP         = 0,
  parameter logic [8:0] BIRTH_MASK   = 9'b000001000,
  parameter logic [8:0] SURVIVE_MASK = 9'b000001100,
  parameter int         GEN_W        = 16,
  localparam int        RW           = $clog2(ROWS),
  localparam int        PW           = $clog2(ROWS*COLS+1)
) (
  input  logic             ClkPort,
  input  logic             Reset_n,
  input  logic             step,
  input  logic             run,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [RW-1:0]    wr_row,
  input  logic [COLS-1:0]  wr_data,
  input  logic [RW-1:0]    rd_row,
  output logic [COLS-1:0]  rd_data,
  output logic             busy,
  output logic             done,
  output logic [GEN_W-1:0] gen_count,
  output logic [PW-1:0]    pop_count,
  output logic             stable,
  output logic             extinct
);

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  typedef struct packed {
    logic [GEN_W-1:0] gen;
    logic [PW-1:0]    pop;
    logic             stable;
    logic             extinct;
  } status_t;

  localparam logic [RW:0]   ROWS_L   = (RW+1)'(ROWS);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS-1);

  state_t          state_q, state_d;
  logic [COLS-1:0] grid [ROWS];
  logic [COLS-1:0] prev_buf, row0_buf;
  logic [RW-1:0]   r_q, r_below;
  logic [PW-1:0]   pop_acc, row_pop;
  logic            changed;
  status_t         stat_q;

  logic [COLS-1:0] above_row, cur_row, below_row, new_row;
  logic            wr_ok, rd_ok;

  assign wr_ok   = {1'b0, wr_row} < ROWS_L;
  assign rd_ok   = {1'b0, rd_row} < ROWS_L;
  assign rd_data = rd_ok ? grid[rd_row] : '0;
  assign r_below = r_q + RW'(1);

  // Row r-1 has already been overwritten, so the old copy comes from prev_buf;
  // likewise old row 0 comes from row0_buf when the last row wraps around.
  always_comb begin
    above_row = prev_buf;
    if (r_q == '0) above_row = (WRAP != 0) ? grid[ROWS-1] : '0;
    cur_row   = grid[r_q];
    below_row = grid[r_below];
    if (r_q == LAST_ROW) below_row = (WRAP != 0) ? row0_buf : '0;
  end

  for (genvar j = 0; j < COLS; j++) begin : g_cell
    localparam int JL     = (j == 0) ? COLS-1 : j-1;
    localparam int JR     = (j == COLS-1) ? 0 : j+1;
    localparam bit EDGE_L = (j == 0) && (WRAP == 0);
    localparam bit EDGE_R = (j == COLS-1) && (WRAP == 0);
    logic       la, lc, lb, ra, rc, rb;
    logic [3:0] nbr;
    assign la  = EDGE_L ? 1'b0 : above_row[JL];
    assign lc  = EDGE_L ? 1'b0 : cur_row[JL];
    assign lb  = EDGE_L ? 1'b0 : below_row[JL];
    assign ra  = EDGE_R ? 1'b0 : above_row[JR];
    assign rc  = EDGE_R ? 1'b0 : cur_row[JR];
    assign rb  = EDGE_R ? 1'b0 : below_row[JR];
    assign nbr = 4'(la) + 4'(above_row[j]) + 4'(ra) + 4'(lc) + 4'(rc)
               + 4'(lb) + 4'(below_row[j]) + 4'(rb);
    assign new_row[j] = cur_row[j] ? SURVIVE_MASK[nbr] : BIRTH_MASK[nbr];
  end

  always_comb begin
    row_pop = '0;
    for (int j = 0; j < COLS; j++) row_pop = row_pop + PW'(new_row[j]);
  end

  always_ff @(posedge ClkPort or negedge Reset_n) begin
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if ((step || run) && !wr_en) state_d = COMPUTE;
        COMPUTE: if (r_q == LAST_ROW) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      COMPUTE: busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge ClkPort or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < ROWS; i++) grid[i] <= '0;
      prev_buf <= '0;
      row0_buf <= '0;
      r_q      <= '0;
      pop_acc  <= '0;
      changed  <= 1'b0;
      stat_q   <= '0;
    end else if (clear) begin
      for (int i = 0; i < ROWS; i++) grid[i] <= '0;
      prev_buf <= '0;
      row0_buf <= '0;
      r_q      <= '0;
      pop_acc  <= '0;
      changed  <= 1'b0;
      stat_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (wr_en) begin
            if (wr_ok) grid[wr_row] <= wr_data;
          end else if (step || run) begin
            row0_buf <= grid[0];
            r_q      <= '0;
            pop_acc  <= '0;
            changed  <= 1'b0;
          end
        end
        COMPUTE: begin
          prev_buf   <= cur_row;
          grid[r_q]  <= new_row;
          pop_acc    <= pop_acc + row_pop;
          changed    <= changed | (new_row != cur_row);
          if (r_q != LAST_ROW) r_q <= r_q + RW'(1);
        end
        DONE: begin
          stat_q.gen     <= stat_q.gen + GEN_W'(1);
          stat_q.pop     <= pop_acc;
          stat_q.stable  <= ~changed;
          stat_q.extinct <= (pop_acc == '0);
        end
        default: ;
      endcase
    end
  end

  assign gen_count = stat_q.gen;
  assign pop_count = stat_q.pop;
  assign stable    = stat_q.stable;
  assign extinct   = stat_q.extinct;

endmodule

// File: tb/tb_life_grid_engine.sv
// Directed + randomized bench: u0 (8x8 dead edge) and u1 (8x8 torus) share stimulus,
// u2 (5x6, 4-bit generation counter) is stepped separately; all checked against an array model.
module tb_life_grid_engine;

  localparam logic [8:0] BIRTH = 9'b000001000;
  localparam logic [8:0] SURV  = 9'b000001100;

  logic clk = 1'b0, rst_n = 1'b1;
  logic step = 1'b0, run = 1'b0, clear = 1'b0, wr_en = 1'b0, step2 = 1'b0, run2 = 1'b0;
  logic [2:0] wr_row = '0, rd_row = '0;
  logic [7:0] wr_data = '0;
  logic [7:0] rd_data0, rd_data1;
  logic [5:0] rd_data2;
  logic busy0, busy1, busy2, done0, done1, done2;
  logic [15:0] gen0, gen1;
  logic [3:0] gen2;
  logic [6:0] pop0, pop1;
  logic [4:0] pop2;
  logic stable0, stable1, stable2, extinct0, extinct1, extinct2;

  int tests = 0, fails = 0;
  bit mg [3][8][8];
  int mgen [3], mpop [3];
  bit mstab [3], mext [3];
  logic [7:0] ginit [8];

  always #50 clk = ~clk;

  life_grid_engine #(.ROWS(8), .COLS(8), .WRAP(0)) u0 (
    .ClkPort(clk), .Reset_n(rst_n), .step(step), .run(run), .clear(clear),
    .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data), .rd_row(rd_row), .rd_data(rd_data0),
    .busy(busy0), .done(done0), .gen_count(gen0), .pop_count(pop0),
    .stable(stable0), .extinct(extinct0));

  life_grid_engine #(.ROWS(8), .COLS(8), .WRAP(1)) u1 (
    .ClkPort(clk), .Reset_n(rst_n), .step(step), .run(run), .clear(clear),
    .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data), .rd_row(rd_row), .rd_data(rd_data1),
    .busy(busy1), .done(done1), .gen_count(gen1), .pop_count(pop1),
    .stable(stable1), .extinct(extinct1));

  life_grid_engine #(.ROWS(5), .COLS(6), .WRAP(0), .GEN_W(4)) u2 (
    .ClkPort(clk), .Reset_n(rst_n), .step(step2), .run(run2), .clear(clear),
    .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data[5:0]), .rd_row(rd_row), .rd_data(rd_data2),
    .busy(busy2), .done(done2), .gen_count(gen2), .pop_count(pop2),
    .stable(stable2), .extinct(extinct2));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) mg[i][r][c] = 1'b0;
      mgen[i] = 0; mpop[i] = 0; mstab[i] = 1'b0; mext[i] = 1'b0;
    end
  endtask

  task automatic model_load(input int r, input logic [7:0] d);
    for (int c = 0; c < 8; c++) begin
      mg[0][r][c] = d[c];
      mg[1][r][c] = d[c];
      if (r < 5 && c < 6) mg[2][r][c] = d[c];
    end
  endtask

  // Plain Life-like rule evaluation with explicit neighbour counting.
  task automatic model_gen(input int idx, input int w, input int nr, input int nc);
    bit nx [8][8];
    int pop, n, rr, cc;
    bit chg;
    pop = 0; chg = 1'b0;
    for (int r = 0; r < nr; r++) begin
      for (int c = 0; c < nc; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr; cc = c + dc;
            if (w != 0) begin rr = (rr + nr) % nr; cc = (cc + nc) % nc; end
            if ((dr != 0 || dc != 0) && rr >= 0 && rr < nr && cc >= 0 && cc < nc)
              n += int'(mg[idx][rr][cc]);
          end
        end
        nx[r][c] = mg[idx][r][c] ? SURV[n] : BIRTH[n];
        pop += int'(nx[r][c]);
        if (nx[r][c] != mg[idx][r][c]) chg = 1'b1;
      end
    end
    for (int r = 0; r < nr; r++) for (int c = 0; c < nc; c++) mg[idx][r][c] = nx[r][c];
    mgen[idx]++; mpop[idx] = pop; mstab[idx] = !chg; mext[idx] = (pop == 0);
  endtask

  function automatic logic [63:0] mrow(input int idx, input int r);
    logic [63:0] v;
    v = '0;
    for (int c = 0; c < 8; c++) v[c] = mg[idx][r][c];
    return v;
  endfunction

  task automatic read_row(input int idx, input int r, output logic [63:0] v);
    rd_row = 3'(r);
    #1;
    case (idx)
      0:       v = 64'(rd_data0);
      1:       v = 64'(rd_data1);
      default: v = 64'(rd_data2);
    endcase
  endtask

  task automatic check_all(input int idx);
    logic [63:0] v, g, p;
    logic s, e, b;
    int nr, md;
    nr = (idx == 2) ? 5 : 8;
    md = (idx == 2) ? 16 : 65536;
    for (int r = 0; r < nr; r++) begin
      read_row(idx, r, v);
      check($sformatf("row_u%0d_r%0d", idx, r), v, mrow(idx, r));
    end
    case (idx)
      0:       begin g = 64'(gen0); p = 64'(pop0); s = stable0; e = extinct0; b = busy0; end
      1:       begin g = 64'(gen1); p = 64'(pop1); s = stable1; e = extinct1; b = busy1; end
      default: begin g = 64'(gen2); p = 64'(pop2); s = stable2; e = extinct2; b = busy2; end
    endcase
    check($sformatf("gen_u%0d", idx), g, 64'(mgen[idx] % md));
    check($sformatf("pop_u%0d", idx), p, 64'(mpop[idx]));
    check($sformatf("stable_u%0d", idx), s, mstab[idx]);
    check($sformatf("extinct_u%0d", idx), e, mext[idx]);
    check($sformatf("busy_u%0d", idx), b, 1'b0);
  endtask

  task automatic load_row(input int r, input logic [7:0] d);
    wr_en = 1'b1; wr_row = 3'(r); wr_data = d;
    tick();
    wr_en = 1'b0;
    model_load(r, d);
  endtask

  task automatic wait_done(input int idx);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (((idx == 2) ? done2 : done0) === 1'b1) begin seen = 1'b1; break; end
      tick();
    end
    check($sformatf("done_seen_u%0d", idx), seen, 1'b1);
  endtask

  task automatic step_pair();
    step = 1'b1;
    tick();
    step = 1'b0;
    wait_done(0);
    check("done_lockstep_u1", done1, 1'b1);
    tick();
    model_gen(0, 0, 8, 8);
    model_gen(1, 1, 8, 8);
  endtask

  task automatic step_u2();
    step2 = 1'b1;
    tick();
    step2 = 1'b0;
    wait_done(2);
    tick();
    model_gen(2, 0, 5, 6);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_clear();
  endtask

  initial begin
    logic [63:0] v;
    bit seen, diff;
    int cnt;
    model_clear();

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", busy0, 1'b0);
    check("rst_done", done0, 1'b0);
    check("rst_gen", gen0, 0);
    check("rst_pop", pop0, 0);
    check("rst_stable", stable0, 1'b0);
    check("rst_extinct", extinct0, 1'b0);
    read_row(0, 0, v);
    check("rst_row0", v, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Blinker with exact timing of busy/done/status
    load_row(3, 8'b00011100);
    step = 1'b1;
    tick();
    step = 1'b0;
    check("blk_busy_t1", busy0, 1'b1);
    check("blk_done_t1", done0, 1'b0);
    repeat (7) tick();
    check("blk_busy_last", busy0, 1'b1);
    tick();
    check("blk_done_pulse", done0, 1'b1);
    check("blk_busy_in_done", busy0, 1'b0);
    check("blk_gen_before", gen0, 0);
    tick();
    check("blk_done_low", done0, 1'b0);
    model_gen(0, 0, 8, 8);
    model_gen(1, 1, 8, 8);
    for (int r = 2; r <= 4; r++) begin
      read_row(0, r, v);
      check($sformatf("blk_row%0d", r), v, 8'b00001000);
    end
    check("blk_pop", pop0, 3);
    check("blk_gen", gen0, 1);
    check("blk_stable", stable0, 1'b0);
    check_all(0);
    check_all(1);
    step_pair();
    read_row(0, 3, v);
    check("blk_restore_r3", v, 8'b00011100);
    check_all(0);
    check_all(1);

    // Still life, then a lone cell dying out
    do_clear();
    load_row(1, 8'b00000110);
    load_row(2, 8'b00000110);
    step_pair();
    check("block_stable", stable0, 1'b1);
    check("block_pop", pop0, 4);
    check_all(0);
    do_clear();
    load_row(4, 8'b00010000);
    step_pair();
    check("lone_pop", pop0, 0);
    check("lone_extinct", extinct0, 1'b1);
    check_all(1);

    // Column-0 edge behaviour
    do_clear();
    load_row(3, 8'h01);
    load_row(4, 8'h01);
    load_row(5, 8'h01);
    step_pair();
    read_row(0, 4, v);
    check("edge_nowrap_r4", v, 8'b00000011);
    read_row(1, 4, v);
    check("edge_wrap_r4", v, 8'b10000011);
    check_all(0);
    check_all(1);

    // Glider across the corner under free-run
    do_clear();
    for (int r = 0; r < 8; r++) ginit[r] = 8'h00;
    ginit[5] = 8'b01000000;
    ginit[6] = 8'b10000000;
    ginit[7] = 8'b11100000;
    for (int r = 5; r < 8; r++) load_row(r, ginit[r]);
    run = 1'b1;
    cnt = 0;
    for (int i = 0; i < 400 && cnt < 32; i++) begin
      tick();
      if (done0 === 1'b1) cnt++;
    end
    run = 1'b0;
    check("glider_gens_seen", cnt, 32);
    tick(); tick();
    check("glider_idle", busy0, 1'b0);
    for (int g = 0; g < 32; g++) begin
      model_gen(0, 0, 8, 8);
      model_gen(1, 1, 8, 8);
    end
    check("glider_gen32", gen1, 32);
    diff = 1'b0;
    for (int r = 0; r < 8; r++) begin
      read_row(1, r, v);
      check($sformatf("glider_wrap_r%0d", r), v, 64'(ginit[r]));
      read_row(0, r, v);
      if (v != 64'(ginit[r])) diff = 1'b1;
    end
    check("glider_nowrap_changed", diff, 1'b1);
    check_all(0);
    check_all(1);

    // Loads and steps while busy are dropped
    do_clear();
    for (int r = 0; r < 8; r++) load_row(r, 8'($urandom_range(0, 255)));
    step = 1'b1;
    tick();
    wr_en = 1'b1; wr_row = 3'd2; wr_data = 8'hFF;
    repeat (3) tick();
    wr_en = 1'b0; step = 1'b0;
    for (int c = 0; c < 6; c++) mg[2][2][c] = 1'b1;
    wait_done(0);
    tick();
    model_gen(0, 0, 8, 8);
    model_gen(1, 1, 8, 8);
    tick(); tick();
    check("no_queued_step", busy0, 1'b0);
    check_all(0);
    check_all(1);
    check_all(2);

    // Simultaneous load and step: load wins
    wr_en = 1'b1; step = 1'b1; wr_row = 3'd5; wr_data = 8'hA5;
    tick();
    wr_en = 1'b0; step = 1'b0;
    model_load(5, 8'hA5);
    check("wr_step_busy", busy0, 1'b0);
    tick();
    check("wr_step_busy2", busy0, 1'b0);
    check_all(0);

    // clear in the middle of a generation
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (3) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_clear();
    check("clr_busy", busy0, 1'b0);
    check("clr_gen", gen0, 0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done0 === 1'b1 || done1 === 1'b1) seen = 1'b1;
      tick();
    end
    check("clr_no_done", seen, 1'b0);
    check_all(0);
    check_all(1);

    // Randomized grids
    for (int k = 0; k < 5; k++) begin
      for (int r = 0; r < 8; r++) load_row(r, 8'($urandom_range(0, 255)));
      step_pair();
      step_pair();
      check_all(0);
      check_all(1);
      step_u2();
      step_u2();
      check_all(2);
      read_row(2, 6, v);
      check("u2_rd_oob", v, 0);
    end

    // 4-bit generation counter wraps after 16 generations
    do_clear();
    for (int r = 0; r < 5; r++) load_row(r, 8'($urandom_range(0, 255)));
    for (int g = 0; g < 16; g++) step_u2();
    check("gen_wrap16", gen2, 0);
    check_all(2);

    // Asynchronous reset mid-run
    for (int r = 0; r < 8; r++) load_row(r, 8'($urandom_range(0, 255)));
    run = 1'b1;
    repeat (15) tick();
    #20 rst_n = 1'b0;
    #1;
    check("arst_busy", busy0, 1'b0);
    check("arst_done", done0, 1'b0);
    check("arst_gen", gen0, 0);
    check("arst_pop", pop0, 0);
    run = 1'b0;
    model_clear();
    read_row(1, 3, v);
    check("arst_row3", v, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check_all(0);
    check_all(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
